// File: rtl/mips32_prog_loader.sv
// mips32_prog_loader
//   Writer side of the mips_32 instruction memory. Takes a valid/ready stream
//   of instruction words, writes them into consecutive memory addresses from a
//   latched base address, holds the core halted while loading, then presets
//   the core pc to the base address and releases it.
//
// Optional feature (compile-time macro LOADER_AUTO_HLT_EN):
//   If the final word of a program is not a HLT, the loader appends one
//   (HLT_OPC in [31:26], all other bits zero) before releasing the core.
//   Without the macro the program is written verbatim.
//
// Ports
//   clk1         core phase-1 clock, the only clock of this block
//   rst          asynchronous active-high reset
//   start        begin a load session (honoured only when not busy)
//   base_addr    first write address, latched on start
//   s_valid/s_data/s_last/s_ready  instruction stream, handshake = valid & ready
//   mem_we/mem_addr/mem_wdata      instruction memory write port (1-cycle latency)
//   cpu_hold     keeps the core halted
//   cpu_release  1-cycle pulse: core loads pc <= cpu_pc_init and leaves halt
//   cpu_pc_init  start pc (latched base_addr)
//   busy         session in progress
//   done         last session completed and core released
//   err_overflow program ran past the top of memory
//   word_count   words written in the current/last session
module mips32_prog_loader #(
  parameter int          ADDR_W  = 10,
  parameter int          DATA_W  = 32,
  parameter logic [5:0]  HLT_OPC = 6'h3f
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              cpu_release,
  output logic [ADDR_W-1:0] cpu_pc_init,
  output logic              busy,
  output logic              done,
  output logic              err_overflow,
  output logic [ADDR_W:0]   word_count
);

`ifdef LOADER_AUTO_HLT_EN
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_APPEND, S_RELEASE, S_DONE, S_ERR
  } state_t;
  localparam logic [DATA_W-1:0] HLT_WORD = {HLT_OPC, {(DATA_W-6){1'b0}}};
`else
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RELEASE, S_DONE, S_ERR
  } state_t;
`endif

  localparam logic [ADDR_W-1:0] PTR_MAX = '1;
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q;
  logic [ADDR_W-1:0]   pc_init_q;
  logic [ADDR_W:0]     count_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                hold_q;
  logic                release_q;
  logic                done_q;
  logic                err_q;

  logic                idle_like;
  logic                hs;
  logic                at_top;

  // DONE and ERR behave like IDLE for accepting a new session.
  assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE) ||
                     (state_q == S_ERR);
  assign hs        = s_valid && s_ready;
  assign at_top    = (wr_ptr_q == PTR_MAX);

  // State register
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (hs) begin
          if (s_last) begin
`ifdef LOADER_AUTO_HLT_EN
            if (s_data[DATA_W-1 -: 6] == HLT_OPC) state_d = S_RELEASE;
            else if (at_top)                      state_d = S_ERR;
            else                                  state_d = S_APPEND;
`else
            state_d = S_RELEASE;
`endif
          end else if (at_top) begin
            // Word at the top address is still written; no wrap afterwards.
            state_d = S_ERR;
          end
        end
      end
`ifdef LOADER_AUTO_HLT_EN
      S_APPEND:  state_d = S_RELEASE;
`endif
      S_RELEASE: state_d = S_DONE;
      default:   state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    s_ready = (state_q == S_LOAD);
    busy    = !idle_like;
  end

  // Write port, pointers and status. The release pulse and hold drop are
  // registered off the RELEASE state, so they appear one cycle after the
  // final memory write is issued and never coincide with it.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      pc_init_q   <= '0;
      count_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hold_q      <= 1'b1;
      release_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      mem_we_q  <= 1'b0;
      release_q <= 1'b0;
      if (idle_like && start) begin
        wr_ptr_q  <= base_addr;
        pc_init_q <= base_addr;
        count_q   <= '0;
        done_q    <= 1'b0;
        err_q     <= 1'b0;
        hold_q    <= 1'b1;
      end
      if (state_q == S_LOAD && hs) begin
        mem_we_q    <= 1'b1;
        mem_addr_q  <= wr_ptr_q;
        mem_wdata_q <= s_data;
        count_q     <= count_q + CNT_ONE;
        if (!at_top) wr_ptr_q <= wr_ptr_q + PTR_ONE;
        if (state_d == S_ERR) err_q <= 1'b1;
      end
`ifdef LOADER_AUTO_HLT_EN
      if (state_q == S_APPEND) begin
        mem_we_q    <= 1'b1;
        mem_addr_q  <= wr_ptr_q;
        mem_wdata_q <= HLT_WORD;
        count_q     <= count_q + CNT_ONE;
      end
`endif
      if (state_q == S_RELEASE) begin
        release_q <= 1'b1;
        hold_q    <= 1'b0;
        done_q    <= 1'b1;
      end
    end
  end

  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign cpu_hold     = hold_q;
  assign cpu_release  = release_q;
  assign cpu_pc_init  = pc_init_q;
  assign done         = done_q;
  assign err_overflow = err_q;
  assign word_count   = count_q;

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Directed testbench for mips32_prog_loader with an 8-word memory (ADDR_W=3),
// small enough to reach the top-of-memory boundary quickly.
module tb_mips32_prog_loader;

  localparam int AW = 3;
  localparam int DW = 32;

  logic          clk1 = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic          s_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          cpu_hold;
  logic          cpu_release;
  logic [AW-1:0] cpu_pc_init;
  logic          busy;
  logic          done;
  logic          err_overflow;
  logic [AW:0]   word_count;

  mips32_prog_loader #(.ADDR_W(AW), .DATA_W(DW), .HLT_OPC(6'h3f)) dut (
    .clk1(clk1), .rst(rst), .start(start), .base_addr(base_addr),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .cpu_release(cpu_release), .cpu_pc_init(cpu_pc_init),
    .busy(busy), .done(done), .err_overflow(err_overflow), .word_count(word_count)
  );

  always #5 clk1 = ~clk1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Write/release monitor, sampled on the falling edge.
  logic [AW-1:0] wa[$];
  logic [DW-1:0] wd[$];
  logic [DW-1:0] ew[$];
  int cyc = 0;
  int last_we_cyc = -1;
  int rel_cnt = 0;

  always @(negedge clk1) begin
    cyc++;
    if (mem_we === 1'b1) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
      last_we_cyc = cyc;
    end
    if (cpu_release === 1'b1) begin
      rel_cnt++;
      chk("release_after_last_write", 64'(cyc > last_we_cyc), 64'd1);
    end
  end

  logic [DW-1:0] prog [7] = '{32'h28000000, 32'h28010005, 32'h28020005,
                              32'h28030019, 32'h00222000, 32'h00a10822,
                              32'hfc000000};

  task automatic clear_log();
    wa.delete(); wd.delete(); ew.delete(); rel_cnt = 0;
  endtask

  task automatic start_sess(input logic [AW-1:0] base);
    @(posedge clk1); #1;
    start = 1'b1; base_addr = base;
    @(posedge clk1); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic last, input int gap);
    logic hs;
    for (int g = 0; g < gap; g++) begin @(posedge clk1); #1; end
    s_valid = 1'b1; s_data = d; s_last = last; hs = 1'b0;
    for (int t = 0; t < 20 && !hs; t++) begin
      @(negedge clk1); hs = s_ready;
      @(posedge clk1); #1;
    end
    s_valid = 1'b0; s_last = 1'b0;
    if (!hs) chk("handshake_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_not_busy();
    logic ok;
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk1); ok = !busy;
    end
    if (!ok) chk("busy_timeout", 64'd0, 64'd1);
    @(posedge clk1); #1;
  endtask

  task automatic check_log(input string tag, input int base);
    chk({tag, "_nwrites"}, 64'(wa.size()), 64'(ew.size()));
    for (int i = 0; i < ew.size() && i < wa.size(); i++) begin
      chk({tag, "_addr"}, 64'(wa[i]), 64'(base + i));
      chk({tag, "_data"}, 64'(wd[i]), 64'(ew[i]));
    end
  endtask

  task automatic run_prog(input string tag, input logic rnd);
    clear_log();
    start_sess(3'd0);
    for (int i = 0; i < 7; i++) begin
      send(prog[i], (i == 6), rnd ? int'($urandom_range(0, 1)) : 0);
      ew.push_back(prog[i]);
    end
    wait_not_busy();
    check_log(tag, 0);
    chk({tag, "_release_pulses"}, 64'(rel_cnt), 64'd1);
    chk({tag, "_pc_init"}, 64'(cpu_pc_init), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_word_count"}, 64'(word_count), 64'd7);
    chk({tag, "_hold"}, 64'(cpu_hold), 64'd0);
    chk({tag, "_err"}, 64'(err_overflow), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0;

    // 1: asynchronous reset takes effect before any clock edge
    #3;
    chk("rst_hold", 64'(cpu_hold), 64'd1);
    chk("rst_ready", 64'(s_ready), 64'd0);
    chk("rst_we", 64'(mem_we), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_release", 64'(cpu_release), 64'd0);
    chk("rst_err", 64'(err_overflow), 64'd0);
    chk("rst_count", 64'(word_count), 64'd0);
    @(posedge clk1); #1; rst = 1'b0;

    // s_valid while idle is never written
    s_valid = 1'b1; s_data = 32'hdeadbeef;
    repeat (3) begin @(posedge clk1); #1; end
    s_valid = 1'b0;
    @(posedge clk1); #1;
    chk("idle_no_write", 64'(wa.size()), 64'd0);

    // 2: basic load
    run_prog("basic", 1'b0);

    // 3: random valid gaps
    run_prog("bp", 1'b1);

    // 4: overflow at top of memory, then recovery
    clear_log();
    start_sess(3'd6);
    send(32'h11111111, 1'b0, 0);
    send(32'h22222222, 1'b0, 0);
    ew.push_back(32'h11111111); ew.push_back(32'h22222222);
    wait_not_busy();
    s_valid = 1'b1; s_data = 32'h33333333;
    repeat (3) begin @(posedge clk1); #1; end
    s_valid = 1'b0;
    @(posedge clk1); #1;
    check_log("ovf", 6);
    chk("ovf_err", 64'(err_overflow), 64'd1);
    chk("ovf_hold", 64'(cpu_hold), 64'd1);
    chk("ovf_ready", 64'(s_ready), 64'd0);
    chk("ovf_release", 64'(rel_cnt), 64'd0);
    chk("ovf_done", 64'(done), 64'd0);
    chk("ovf_count", 64'(word_count), 64'd2);
    clear_log();
    start_sess(3'd2);
    chk("recover_err_cleared", 64'(err_overflow), 64'd0);
    send(32'hfc000000, 1'b1, 0);
    ew.push_back(32'hfc000000);
    wait_not_busy();
    check_log("recover", 2);
    chk("recover_done", 64'(done), 64'd1);
    chk("recover_release", 64'(rel_cnt), 64'd1);
    chk("recover_pc", 64'(cpu_pc_init), 64'd2);

    // 5: final word without HLT
    clear_log();
    start_sess(3'd4);
    send(32'h28010005, 1'b0, 0);
    send(32'h00222000, 1'b1, 0);
    ew.push_back(32'h28010005); ew.push_back(32'h00222000);
`ifdef LOADER_AUTO_HLT_EN
    ew.push_back(32'hfc000000);
`endif
    wait_not_busy();
    check_log("autohlt", 4);
    chk("autohlt_count", 64'(word_count), 64'(ew.size()));
    chk("autohlt_release", 64'(rel_cnt), 64'd1);
    chk("autohlt_pc", 64'(cpu_pc_init), 64'd4);

    // 6: reset mid-load, then clean reload
    clear_log();
    start_sess(3'd0);
    chk("restart_done_cleared", 64'(done), 64'd0);
    chk("restart_hold", 64'(cpu_hold), 64'd1);
    for (int i = 0; i < 3; i++) send(prog[i], 1'b0, 0);
    @(posedge clk1); #3;
    rst = 1'b1;
    #1;
    chk("midrst_hold", 64'(cpu_hold), 64'd1);
    chk("midrst_ready", 64'(s_ready), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_count", 64'(word_count), 64'd0);
    chk("midrst_partial_writes", 64'(wa.size()), 64'd3);
    @(posedge clk1); #1; rst = 1'b0;
    repeat (3) begin @(posedge clk1); #1; end
    chk("midrst_no_release", 64'(rel_cnt), 64'd0);
    run_prog("reload", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
